// File: rtl/sequenciador_noite_if.sv
// +----------------------------------------------------------------------------+
// | Module   : sequenciador_noite_if                                           |
// | Purpose  : Control/status bundle between the game control unit and the    |
// |            night-phase sequencer.                                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sequenciador_noite_if #(
  parameter int NJOG = 5
) ();
  logic                inicia;
  logic [2*NJOG-1:0]   jogo;
  logic [NJOG-1:0]     vivos;
  logic [2:0]          escolha;
  logic                confirma;

  logic                vez_lobo;
  logic                vez_medico;
  logic                erro_escolha;
  logic                fim_noite;
  logic                houve_morte;
  logic [2:0]          morto;
  logic [NJOG-1:0]     vivos_out;
  logic [4:0]          db_estado;

  modport master (
    output inicia, jogo, vivos, escolha, confirma,
    input  vez_lobo, vez_medico, erro_escolha, fim_noite, houve_morte,
           morto, vivos_out, db_estado
  );

  modport slave (
    input  inicia, jogo, vivos, escolha, confirma,
    output vez_lobo, vez_medico, erro_escolha, fim_noite, houve_morte,
           morto, vivos_out, db_estado
  );
endinterface

`default_nettype wire

// File: rtl/sequenciador_noite.sv
// +----------------------------------------------------------------------------+
// | Module   : sequenciador_noite                                              |
// | Purpose  : Night-phase controller: wolf turn, doctor turn, kill/save       |
// |            resolution and publication of the updated alive mask.          |
// | Options  : SEQ_NOITE_TEMPO_LIMITE_EN enables the per-turn timeout counter. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sequenciador_noite #(
  parameter int NJOG         = 5,
  parameter int TEMPO_LIMITE = 50_000_000,
  parameter int NT           = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  sequenciador_noite_if.slave  bus
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    VEZ_LOBO   = 3'd1,
    VEZ_MEDICO = 3'd2,
    RESOLVE    = 3'd3,
    FIM        = 3'd4
  } estado_t;

  localparam logic [1:0] C_COD_LOBO   = 2'b01;
  localparam logic [1:0] C_COD_MEDICO = 2'b10;
  localparam logic [3:0] C_NJOG       = 4'(NJOG);

  // Returns {found, index} of the lowest-index player holding role code cod.
  function automatic logic [3:0] acha_papel(input logic [2*NJOG-1:0] mapa,
                                            input logic [1:0]        cod);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = NJOG - 1; i >= 0; i--) begin
      if (mapa[2*NJOG-1-2*i -: 2] == cod) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  function automatic logic vivo(input logic [NJOG-1:0] m, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NJOG; i++) begin
      if (idx == 3'(i)) begin
        r = m[i];
      end
    end
    return r;
  endfunction

  function automatic logic [NJOG-1:0] um_quente(input logic [2:0] idx);
    logic [NJOG-1:0] r;
    r = '0;
    for (int i = 0; i < NJOG; i++) begin
      if (idx == 3'(i)) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  estado_t           state_q, state_d;
  logic [2*NJOG-1:0] jogo_q, jogo_d;
  logic [NJOG-1:0]   vivos_q, vivos_d;
  logic [2:0]        vitima_q, vitima_d;
  logic              tem_vitima_q, tem_vitima_d;
  logic [2:0]        salvo_q, salvo_d;
  logic              tem_salvo_q, tem_salvo_d;
  logic              erro_q, erro_d;
  logic              houve_q, houve_d;
  logic [2:0]        morto_q, morto_d;
  logic [NJOG-1:0]   vivos_out_q, vivos_out_d;

  logic [2*NJOG-1:0] w_jogo_sel;
  logic [NJOG-1:0]   w_vivos_sel;
  logic [3:0]        w_lobo;
  logic [3:0]        w_medico;
  logic              w_lobo_pres;
  logic              w_medico_pres;
  logic              w_escolha_ok;
  logic              w_lobo_ok;
  logic              w_medico_ok;
  logic              w_morte;
  logic              w_fim_turno;

  // In OCIOSO the actor lookup must see the values being captured on this edge.
  assign w_jogo_sel    = (state_q == OCIOSO) ? bus.jogo  : jogo_q;
  assign w_vivos_sel   = (state_q == OCIOSO) ? bus.vivos : vivos_q;
  assign w_lobo        = acha_papel(w_jogo_sel, C_COD_LOBO);
  assign w_medico      = acha_papel(w_jogo_sel, C_COD_MEDICO);
  assign w_lobo_pres   = w_lobo[3]   && vivo(w_vivos_sel, w_lobo[2:0]);
  assign w_medico_pres = w_medico[3] && vivo(w_vivos_sel, w_medico[2:0]);

  assign w_escolha_ok  = ({1'b0, bus.escolha} < C_NJOG) && vivo(vivos_q, bus.escolha);
  assign w_lobo_ok     = w_escolha_ok && (bus.escolha != w_lobo[2:0]);
  assign w_medico_ok   = w_escolha_ok;

  assign w_morte = tem_vitima_q && (!tem_salvo_q || (salvo_q != vitima_q));

`ifdef SEQ_NOITE_TEMPO_LIMITE_EN
  localparam logic [NT-1:0] C_TEMPO_FIM = NT'(TEMPO_LIMITE - 1);

  logic [NT-1:0] tempo_q, tempo_d;

  // Counter restarts on every state change so each turn gets a full budget.
  always_comb begin
    tempo_d = '0;
    if (((state_q == VEZ_LOBO) || (state_q == VEZ_MEDICO)) && (state_d == state_q)) begin
      tempo_d = tempo_q + NT'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tempo_q <= '0;
    end else begin
      tempo_q <= tempo_d;
    end
  end

  assign w_fim_turno = ((state_q == VEZ_LOBO) || (state_q == VEZ_MEDICO)) &&
                       (tempo_q == C_TEMPO_FIM);
`else
  assign w_fim_turno = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    jogo_d       = jogo_q;
    vivos_d      = vivos_q;
    vitima_d     = vitima_q;
    tem_vitima_d = tem_vitima_q;
    salvo_d      = salvo_q;
    tem_salvo_d  = tem_salvo_q;
    erro_d       = 1'b0;
    houve_d      = houve_q;
    morto_d      = morto_q;
    vivos_out_d  = vivos_out_q;

    case (state_q)
      OCIOSO: begin
        if (bus.inicia) begin
          jogo_d       = bus.jogo;
          vivos_d      = bus.vivos;
          vitima_d     = 3'd0;
          tem_vitima_d = 1'b0;
          salvo_d      = 3'd0;
          tem_salvo_d  = 1'b0;
          houve_d      = 1'b0;
          morto_d      = 3'd0;
          if (w_lobo_pres) begin
            state_d = VEZ_LOBO;
          end else if (w_medico_pres) begin
            state_d = VEZ_MEDICO;
          end else begin
            state_d = RESOLVE;
          end
        end
      end

      VEZ_LOBO: begin
        if (bus.confirma && w_lobo_ok) begin
          vitima_d     = bus.escolha;
          tem_vitima_d = 1'b1;
          state_d      = w_medico_pres ? VEZ_MEDICO : RESOLVE;
        end else begin
          erro_d = bus.confirma;
          if (w_fim_turno) begin
            state_d = w_medico_pres ? VEZ_MEDICO : RESOLVE;
          end
        end
      end

      VEZ_MEDICO: begin
        if (bus.confirma && w_medico_ok) begin
          salvo_d     = bus.escolha;
          tem_salvo_d = 1'b1;
          state_d     = RESOLVE;
        end else begin
          erro_d = bus.confirma;
          if (w_fim_turno) begin
            state_d = RESOLVE;
          end
        end
      end

      RESOLVE: begin
        houve_d     = w_morte;
        morto_d     = w_morte ? vitima_q : 3'd0;
        vivos_out_d = w_morte ? (vivos_q & ~um_quente(vitima_q)) : vivos_q;
        state_d     = FIM;
      end

      FIM: begin
        state_d = OCIOSO;
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= OCIOSO;
      jogo_q       <= '0;
      vivos_q      <= '0;
      vitima_q     <= 3'd0;
      tem_vitima_q <= 1'b0;
      salvo_q      <= 3'd0;
      tem_salvo_q  <= 1'b0;
      erro_q       <= 1'b0;
      houve_q      <= 1'b0;
      morto_q      <= 3'd0;
      vivos_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      jogo_q       <= jogo_d;
      vivos_q      <= vivos_d;
      vitima_q     <= vitima_d;
      tem_vitima_q <= tem_vitima_d;
      salvo_q      <= salvo_d;
      tem_salvo_q  <= tem_salvo_d;
      erro_q       <= erro_d;
      houve_q      <= houve_d;
      morto_q      <= morto_d;
      vivos_out_q  <= vivos_out_d;
    end
  end

  always_comb begin
    bus.db_estado = 5'b11111;
    case (state_q)
      OCIOSO, VEZ_LOBO, VEZ_MEDICO, RESOLVE, FIM: bus.db_estado = {2'b00, state_q};
      default:                                    bus.db_estado = 5'b11111;
    endcase
  end

  assign bus.vez_lobo     = (state_q == VEZ_LOBO);
  assign bus.vez_medico   = (state_q == VEZ_MEDICO);
  assign bus.fim_noite    = (state_q == FIM);
  assign bus.erro_escolha = erro_q;
  assign bus.houve_morte  = houve_q;
  assign bus.morto        = morto_q;
  assign bus.vivos_out    = vivos_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_noite.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_sequenciador_noite                                           |
// | Purpose  : Directed self-checking bench for the night-phase sequencer.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sequenciador_noite;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  sequenciador_noite_if #(.NJOG(5)) bus ();

  sequenciador_noite #(
    .NJOG         (5),
    .TEMPO_LIMITE (8),
    .NT           (26)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic pulso_inicia(input logic [9:0] j, input logic [4:0] v);
    bus.jogo   = j;
    bus.vivos  = v;
    bus.inicia = 1'b1;
    @(negedge clock);
    bus.inicia = 1'b0;
  endtask

  task automatic pulso_confirma(input logic [2:0] e);
    bus.escolha  = e;
    bus.confirma = 1'b1;
    @(negedge clock);
    bus.confirma = 1'b0;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.inicia   = 1'b0;
    bus.confirma = 1'b0;
    bus.escolha  = 3'd0;
    bus.jogo     = 10'd0;
    bus.vivos    = 5'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    total++;
    if (bus.db_estado !== 5'd0) begin
      bad++; $display("FAIL reset_estado: got %0d required 0", bus.db_estado);
    end
    total++;
    if ({bus.vez_lobo, bus.vez_medico, bus.erro_escolha, bus.fim_noite, bus.houve_morte} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 00000",
                      {bus.vez_lobo, bus.vez_medico, bus.erro_escolha, bus.fim_noite, bus.houve_morte});
    end
    total++;
    if ({bus.morto, bus.vivos_out} !== 8'd0) begin
      bad++; $display("FAIL reset_dados: got morto=%0d vivos_out=%b required 0 00000", bus.morto, bus.vivos_out);
    end
  endtask

  task automatic test_normal_kill;
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    total++;
    if (bus.db_estado !== 5'd1 || bus.vez_lobo !== 1'b1) begin
      bad++; $display("FAIL kill_inicio: got estado=%0d vez_lobo=%b required 1 1", bus.db_estado, bus.vez_lobo);
    end
    pulso_confirma(3'd3);
    total++;
    if (bus.db_estado !== 5'd2 || bus.vez_medico !== 1'b1) begin
      bad++; $display("FAIL kill_medico: got estado=%0d vez_medico=%b required 2 1", bus.db_estado, bus.vez_medico);
    end
    pulso_confirma(3'd1);
    total++;
    if (bus.db_estado !== 5'd3 || bus.fim_noite !== 1'b0) begin
      bad++; $display("FAIL kill_resolve: got estado=%0d fim=%b required 3 0", bus.db_estado, bus.fim_noite);
    end
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd3, 5'b10111}) begin
      bad++; $display("FAIL kill_fim: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 3 10111",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.db_estado, bus.houve_morte, bus.morto, bus.vivos_out} !==
        {1'b0, 5'd0, 1'b1, 3'd3, 5'b10111}) begin
      bad++; $display("FAIL kill_hold: got fim=%b estado=%0d houve=%b morto=%0d vivos_out=%b required 0 0 1 3 10111",
                      bus.fim_noite, bus.db_estado, bus.houve_morte, bus.morto, bus.vivos_out);
    end
  endtask

  task automatic test_save;
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    pulso_confirma(3'd3);
    pulso_confirma(3'd3);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b0, 3'd0, 5'b11111}) begin
      bad++; $display("FAIL save_fim: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 0 0 11111",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_invalid;
    logic [2:0] ruins [3];
    int         pulsos;
    ruins[0] = 3'd0;
    ruins[1] = 3'd5;
    ruins[2] = 3'd4;
    pulsos   = 0;
    pulso_inicia(10'b01_10_00_00_00, 5'b01111);
    for (int i = 0; i < 3; i++) begin
      pulso_confirma(ruins[i]);
      if (bus.erro_escolha === 1'b1) pulsos++;
      total++;
      if (bus.db_estado !== 5'd1) begin
        bad++; $display("FAIL invalid_estado%0d: got %0d required 1", i, bus.db_estado);
      end
    end
    total++;
    if (pulsos !== 3) begin
      bad++; $display("FAIL invalid_pulsos: got %0d required 3", pulsos);
    end
    @(negedge clock);
    total++;
    if (bus.erro_escolha !== 1'b0) begin
      bad++; $display("FAIL invalid_largura: got erro=%b required 0", bus.erro_escolha);
    end
    pulso_confirma(3'd2);
    total++;
    if (bus.db_estado !== 5'd2 || bus.erro_escolha !== 1'b0) begin
      bad++; $display("FAIL invalid_aceita: got estado=%0d erro=%b required 2 0", bus.db_estado, bus.erro_escolha);
    end
    pulso_confirma(3'd4);
    total++;
    if (bus.db_estado !== 5'd2 || bus.erro_escolha !== 1'b1) begin
      bad++; $display("FAIL invalid_medico: got estado=%0d erro=%b required 2 1", bus.db_estado, bus.erro_escolha);
    end
    pulso_confirma(3'd1);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd2, 5'b01011}) begin
      bad++; $display("FAIL invalid_fim: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 2 01011",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_dead_doctor;
    pulso_inicia(10'b01_10_00_00_00, 5'b11101);
    pulso_confirma(3'd2);
    total++;
    if (bus.db_estado !== 5'd3) begin
      bad++; $display("FAIL dead_doctor_skip: got %0d required 3", bus.db_estado);
    end
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd2, 5'b11001}) begin
      bad++; $display("FAIL dead_doctor_fim: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 2 11001",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    pulso_confirma(3'd3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if ({bus.db_estado, bus.vez_medico, bus.houve_morte, bus.morto, bus.vivos_out} !== 15'd0) begin
      bad++; $display("FAIL reset_mid: got estado=%0d vez_medico=%b houve=%b morto=%0d vivos_out=%b required all 0",
                      bus.db_estado, bus.vez_medico, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    pulso_confirma(3'd2);
    pulso_confirma(3'd0);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd2, 5'b11011}) begin
      bad++; $display("FAIL reset_mid_nova: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 2 11011",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_no_actors;
    pulso_inicia(10'b00_00_11_00_00, 5'b11111);
    total++;
    if (bus.db_estado !== 5'd3) begin
      bad++; $display("FAIL no_actors_resolve: got %0d required 3", bus.db_estado);
    end
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.vivos_out} !== {1'b1, 1'b0, 5'b11111}) begin
      bad++; $display("FAIL no_actors_fim: got fim=%b houve=%b vivos_out=%b required 1 0 11111",
                      bus.fim_noite, bus.houve_morte, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_ignored;
    pulso_confirma(3'd1);
    total++;
    if (bus.db_estado !== 5'd0 || bus.erro_escolha !== 1'b0) begin
      bad++; $display("FAIL ignored_confirma: got estado=%0d erro=%b required 0 0", bus.db_estado, bus.erro_escolha);
    end
    // Lowest-index wolf (player 0) is dead, so the night starts with the doctor.
    pulso_inicia(10'b01_01_10_00_00, 5'b11110);
    total++;
    if (bus.db_estado !== 5'd2) begin
      bad++; $display("FAIL lowest_wolf_dead: got %0d required 2", bus.db_estado);
    end
    pulso_inicia(10'b00_00_00_00_00, 5'b00000);
    total++;
    if (bus.db_estado !== 5'd2) begin
      bad++; $display("FAIL ignored_inicia: got %0d required 2", bus.db_estado);
    end
    pulso_confirma(3'd1);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.vivos_out} !== {1'b1, 1'b0, 5'b11110}) begin
      bad++; $display("FAIL ignored_fim: got fim=%b houve=%b vivos_out=%b required 1 0 11110",
                      bus.fim_noite, bus.houve_morte, bus.vivos_out);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    // Code 11 counts as villager: doctor is player 1, wolf is player 2.
    pulso_inicia(10'b11_10_01_00_00, 5'b11111);
    pulso_confirma(3'd2);
    total++;
    if (bus.db_estado !== 5'd1 || bus.erro_escolha !== 1'b1) begin
      bad++; $display("FAIL b2b_self_wolf: got estado=%0d erro=%b required 1 1", bus.db_estado, bus.erro_escolha);
    end
    pulso_confirma(3'd0);
    pulso_confirma(3'd1);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd0, 5'b11110}) begin
      bad++; $display("FAIL b2b_fim: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 0 11110",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
    pulso_inicia(10'b11_10_01_00_00, 5'b11111);
    pulso_confirma(3'd4);
    pulso_confirma(3'd1);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out} !== {1'b1, 1'b1, 3'd4, 5'b01111}) begin
      bad++; $display("FAIL b2b_segunda: got fim=%b houve=%b morto=%0d vivos_out=%b required 1 1 4 01111",
                      bus.fim_noite, bus.houve_morte, bus.morto, bus.vivos_out);
    end
    @(negedge clock);
  endtask

`ifdef SEQ_NOITE_TEMPO_LIMITE_EN
  task automatic test_timeout;
    int n;
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    n = 0;
    while (bus.vez_lobo === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL timeout_lobo: got %0d cycles required 8", n);
    end
    n = 0;
    while (bus.vez_medico === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL timeout_medico: got %0d cycles required 8", n);
    end
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte, bus.vivos_out} !== {1'b1, 1'b0, 5'b11111}) begin
      bad++; $display("FAIL timeout_fim: got fim=%b houve=%b vivos_out=%b required 1 0 11111",
                      bus.fim_noite, bus.houve_morte, bus.vivos_out);
    end
    @(negedge clock);
  endtask
`else
  task automatic test_timeout;
    pulso_inicia(10'b01_10_00_00_00, 5'b11111);
    repeat (30) @(negedge clock);
    total++;
    if (bus.db_estado !== 5'd1) begin
      bad++; $display("FAIL espera_lobo: got %0d required 1", bus.db_estado);
    end
    pulso_confirma(3'd3);
    pulso_confirma(3'd3);
    @(negedge clock);
    total++;
    if ({bus.fim_noite, bus.houve_morte} !== 2'b10) begin
      bad++; $display("FAIL espera_fim: got fim=%b houve=%b required 1 0", bus.fim_noite, bus.houve_morte);
    end
    @(negedge clock);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_normal_kill();
    test_save();
    test_invalid();
    test_dead_doctor();
    test_reset_mid();
    test_no_actors();
    test_ignored();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sequenciador_noite.md
# sequenciador_noite

Night-phase controller for the game datapath. It sits after the seed register: it latches the current role map (`jogo`, 10 bits) and alive mask, then sequences the wolf's turn and the doctor's turn. Each turn collects one validated player choice. It then resolves the kill/save outcome and publishes the updated alive mask. The top-level control unit starts it from the night-preparation state and waits for `fim_noite`.

## Interface
Parameters:
- `NJOG`, 5: number of players. The role map is fixed at 2 bits per player.
- `TEMPO_LIMITE`, 50_000_000: turn timeout in clock cycles (1 s at 50 MHz). Used only when the timeout feature is compiled in.
- `NT`, 26: width of the timeout counter.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high. Returns the block to OCIOSO and clears all registers.
- `inicia`  in  1: start-night pulse. Honoured only in OCIOSO.
- `jogo`  in  10: role map. Player i occupies bits [9-2i:8-2i]. Encoding: 00 aldeão, 01 lobo, 10 médico; 11 is treated as aldeão.
- `vivos`  in  5: alive mask; bit i = player i alive.
- `escolha`  in  3: player index chosen by the current actor.
- `confirma`  in  1: one-cycle pulse that submits `escolha`. Produced upstream by the edge detector.
- `vez_lobo`  out  1: high while in VEZ_LOBO.
- `vez_medico`  out  1: high while in VEZ_MEDICO.
- `erro_escolha`  out  1: one-cycle pulse when a submitted choice is rejected.
- `fim_noite`  out  1: one-cycle pulse in FIM.
- `houve_morte`  out  1: a player died this night. Valid from FIM until the next `inicia`.
- `morto`  out  3: index of the dead player. Valid with `houve_morte`, otherwise 0.
- `vivos_out`  out  5: alive mask after resolution. Held until the next `inicia`.
- `db_estado`  out  5: state code for debug displays.

## Operation
- **Capture.** On `inicia` in OCIOSO, `jogo` and `vivos` are registered. All later decisions use the registered copies. The selected victim and save registers are cleared.
- **Actor lookup.** The wolf is the lowest-index player with code 01; the doctor is the lowest-index player with code 10. An actor counts as present only if its `vivos` bit is 1.
- **States and codes:**
  - OCIOSO = 0
  - VEZ_LOBO = 1
  - VEZ_MEDICO = 2
  - RESOLVE = 3
  - FIM = 4
  - any other code: `db_estado` = 5'b11111 and next state is OCIOSO.
- **Transitions:**
  - OCIOSO → VEZ_LOBO if the wolf is present. Otherwise → VEZ_MEDICO if the doctor is present, otherwise → RESOLVE.
  - VEZ_LOBO: valid `confirma` → register victim, then go to VEZ_MEDICO if the doctor is present, otherwise to RESOLVE.
  - VEZ_MEDICO: valid `confirma` → register save, go to RESOLVE.
  - RESOLVE → FIM (one cycle).
  - FIM → OCIOSO (one cycle).
- **Validation.**
  - A wolf choice is valid if `escolha` < NJOG, the chosen player is alive, and it is not the wolf itself.
  - A doctor choice is valid if `escolha` < NJOG and the chosen player is alive; self-save is allowed.
  - An invalid `confirma` pulses `erro_escolha` and stays in the same state. Nothing is registered.
- **Resolve.** `houve_morte` = victim registered AND (no save registered OR save ≠ victim). `vivos_out` = registered mask with bit `morto` cleared when `houve_morte`, otherwise the registered mask unchanged.
- **Ignored inputs.** `inicia` outside OCIOSO is ignored. `confirma` outside VEZ_* states is ignored.
- **Reset.** Reset in any state (including mid-turn) discards all choices.
- **Reset values.** Every output is 0, except `vivos_out` = 5'b00000 and `db_estado` = 0.

## Timing
- **Start.** `inicia` sampled at edge k → state leaves OCIOSO at edge k+1. `vez_lobo` is visible in cycle k+1.
- **Choice accepted.** `confirma` sampled at edge t → the next state is active from edge t+1. `erro_escolha` is registered: it is high for exactly the cycle after edge t.
- **Result.** The last valid choice at edge t gives RESOLVE at t+1 and FIM at t+2. `fim_noite`, `houve_morte`, `morto` and `vivos_out` are valid from t+2. `fim_noite` drops at t+3, while the other outputs hold.
- **No actors.** With neither actor present, `inicia` at edge k gives `fim_noite` in cycle k+2 with no death.
- **Precedence.** Reset has priority over every other input on the same edge. A `confirma` on the same edge as a timeout is evaluated as a normal choice, and the choice wins.

## Configuration
- `SEQ_NOITE_TEMPO_LIMITE_EN` defined:
  - A turn counter clears on entry to each VEZ_* state.
  - It increments every cycle spent in that state.
  - When it reaches `TEMPO_LIMITE`-1, the turn ends with no selection (no victim, or no save), and the FSM proceeds as for a valid choice.
- Macro undefined: no counter exists, and the FSM waits in VEZ_* indefinitely.

## Test plan
- **Normal kill.** `jogo`=10'b01_10_00_00_00, `vivos`=11111; wolf confirms 3, doctor confirms 1 → `houve_morte`=1, `morto`=3, `vivos_out`=10111, `fim_noite` 2 cycles after the doctor's confirm.
- **Save.** Same setup; wolf picks 3, doctor picks 3 → `houve_morte`=0, `vivos_out`=11111.
- **Invalid choices.** In VEZ_LOBO, confirm 0 (self), then 5, then 4 with `vivos`=01111 → three `erro_escolha` pulses, state stays 1. Then confirm 2 → state 2.
- **Dead doctor.** `vivos`=11101; wolf picks 2 → VEZ_MEDICO is skipped, `morto`=2, `vivos_out`=11001.
- **Reset mid-turn.** Reset in VEZ_MEDICO → next cycle `db_estado`=0 and all outputs 0. A new `inicia` runs a clean night.
- **Timeout.** With `SEQ_NOITE_TEMPO_LIMITE_EN` and `TEMPO_LIMITE`=8, no `confirma` is given → VEZ_LOBO lasts 8 cycles and VEZ_MEDICO lasts 8 cycles, then `fim_noite` with `houve_morte`=0.
